// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the 16-bit CPU core and its memory-side
// responder (cpu_stim_mem).
//   - 5-bit opcode constants. The opcode occupies instruction bits [15:11].
//   - State encoding for the cpu_stim_mem sequencer.
//   - opcode_of(): extracts the opcode field from an instruction word.
package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_NOP   = 5'b00000;
    localparam opcode_t OP_HALT  = 5'b00001;
    localparam opcode_t OP_LOAD  = 5'b00010;
    localparam opcode_t OP_STORE = 5'b00011;
    localparam opcode_t OP_ADD   = 5'b00100;
    localparam opcode_t OP_SUB   = 5'b00101;
    localparam opcode_t OP_AND   = 5'b00110;
    localparam opcode_t OP_OR    = 5'b00111;
    localparam opcode_t OP_XOR   = 5'b01000;

    // Instruction word the CPU treats as "do nothing".
    localparam logic [15:0] NOP_WORD = {OP_NOP, 11'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } stim_state_e;

    function automatic opcode_t opcode_of(input logic [15:0] word);
        return word[15:11];
    endfunction

endpackage

// File: rtl/dmem_sp256x16.sv
// dmem_sp256x16: 256 x 16 synchronous RAM, one write port, one registered read.
//   clock  in   rising-edge clock
//   reset  in   async active-high; clears only the read data register
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data, one cycle after raddr
// A read of the address being written in the same cycle returns the old word.
module dmem_sp256x16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [7:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem_q [256];

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/cpu_stim_mem.sv
// cpu_stim_mem: memory-side responder for the 16-bit CPU.
// Streams a loaded program onto i_datain after a run request and serves a
// 256-word data RAM on the CPU's d_* port.
//   clock, reset            rising-edge clock, async active-high reset
//   load_en/sel/addr/data   load port (sel 0: program buffer, 1: data RAM);
//                           accepted only in IDLE or DONE
//   run                     start-of-program request pulse
//   cpu_start               one-cycle start pulse to the CPU
//   i_datain                instruction word to the CPU
//   d_addr/d_dataout/d_we   CPU data address, store data, store enable
//   d_datain                registered load data to the CPU
//   busy, done              sequencer status (START/RUN/DRAIN, DONE)
module cpu_stim_mem
    import cpu_pkg::*;
#(
    parameter int PROG_DEPTH   = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        run,
    output logic        cpu_start,
    output logic [15:0] i_datain,
    input  logic [7:0]  d_addr,
    input  logic [15:0] d_dataout,
    input  logic        d_we,
    output logic [15:0] d_datain,
    output logic        busy,
    output logic        done
);

    localparam int PW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    stim_state_e       state_q;
    logic [PW:0]       ptr_q;       // one extra bit: ptr reaches prog_len without wrapping
    logic [PW:0]       prog_len_q;
    logic [DW-1:0]     drain_q;
    logic              cpu_start_q;
    logic [15:0]       i_data_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       prog_q [PROG_DEPTH];

    // A run request takes priority over a load in the same cycle.
    logic              load_ok;
    logic              prog_we;
    logic              ram_ld_we;
    logic [PW-1:0]     prog_addr;
    logic [PW:0]       prog_len_d;
    logic [PROG_DEPTH-1:0] prog_hit;

    assign load_ok    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !run;
    assign prog_we    = load_ok && load_en && !load_sel;
    assign ram_ld_we  = load_ok && load_en && load_sel;
    assign prog_addr  = load_addr[PW-1:0];
    assign prog_len_d = ({1'b0, prog_addr} + 1'b1 > prog_len_q) ?
                        ({1'b0, prog_addr} + 1'b1) : prog_len_q;

    genvar gi;
    generate
        for (gi = 0; gi < PROG_DEPTH; gi++) begin : g_prog_hit
            assign prog_hit[gi] = prog_we && (prog_addr == PW'(gi));
        end
    endgenerate

    // Program buffer and its length are cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                prog_q[i] <= '0;
            end
            prog_len_q <= '0;
        end else begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                if (prog_hit[i]) begin
                    prog_q[i] <= load_data;
                end
            end
            if (prog_we) begin
                prog_len_q <= prog_len_d;
            end
        end
    end

    // Sequencer. Outputs are registered: each transition loads the value
    // that i_datain/cpu_start/busy/done must show in the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            drain_q     <= '0;
            cpu_start_q <= 1'b0;
            i_data_q    <= NOP_WORD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cpu_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        state_q     <= ST_START;
                        ptr_q       <= '0;
                        cpu_start_q <= 1'b1;
                        i_data_q    <= NOP_WORD;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (prog_len_q == '0) begin
                        state_q  <= ST_DRAIN;
                        drain_q  <= '0;
                        i_data_q <= NOP_WORD;
                    end else begin
                        state_q  <= ST_RUN;
                        i_data_q <= prog_q[0];
                        ptr_q    <= (PW + 1)'(1);
                    end
                end
                ST_RUN: begin
                    // i_data_q holds the word issued this cycle; ptr_q already
                    // points past it, so ptr_q == prog_len_q marks the last word.
                    if ((opcode_of(i_data_q) == OP_HALT) || (ptr_q == prog_len_q)) begin
                        state_q  <= ST_DRAIN;
                        drain_q  <= '0;
                        i_data_q <= NOP_WORD;
                    end else begin
                        i_data_q <= prog_q[ptr_q[PW-1:0]];
                        ptr_q    <= ptr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data RAM has one write port: a CPU store takes it over any load-port write.
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;

    assign ram_we    = d_we || ram_ld_we;
    assign ram_waddr = d_we ? d_addr    : load_addr;
    assign ram_wdata = d_we ? d_dataout : load_data;

    dmem_sp256x16 u_dmem (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (d_addr),
        .rdata (d_datain)
    );

    assign cpu_start = cpu_start_q;
    assign i_datain  = i_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cpu_stim_mem.sv
module tb_cpu_stim_mem;

    localparam int DRAIN = 3;

    logic        clock;
    logic        reset;
    logic        load_en;
    logic        load_sel;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        run;
    logic        cpu_start;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    logic [15:0] exp_w [8];

    cpu_stim_mem #(
        .PROG_DEPTH   (16),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .run       (run),
        .cpu_start (cpu_start),
        .i_datain  (i_datain),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we),
        .d_datain  (d_datain),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [7:0] addr, input logic [15:0] data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
        $display("[TB] load sel=%0d addr=%02h data=%04h", sel, addr, data);
    endtask

    // Pulses run and checks the whole sequence: START, n words from exp_w,
    // DRAIN NOPs, then DONE. poke drives run+load during RUN (must be ignored);
    // ld_with_run drives a program load together with run (must be dropped).
    task automatic run_prog(input string name, input int n, input bit poke, input bit ld_with_run);
        run = 1'b1;
        if (ld_with_run) begin
            load_en   = 1'b1;
            load_sel  = 1'b0;
            load_addr = 8'd1;
            load_data = 16'h2222;
        end
        tick();
        run     = 1'b0;
        load_en = 1'b0;
        chk1({name, "/start_pulse"}, cpu_start, 1'b1);
        chk1({name, "/start_busy"}, busy, 1'b1);
        chk16({name, "/start_nop"}, i_datain, 16'h0000);
        for (int i = 0; i < n; i++) begin
            tick();
            run     = 1'b0;
            load_en = 1'b0;
            chk16($sformatf("%s/word%0d", name, i), i_datain, exp_w[i]);
            chk1($sformatf("%s/no_start%0d", name, i), cpu_start, 1'b0);
            chk1($sformatf("%s/busy%0d", name, i), busy, 1'b1);
            if (poke && i == 1) begin
                run       = 1'b1;
                load_en   = 1'b1;
                load_sel  = 1'b0;
                load_addr = 8'd7;
                load_data = 16'h0800;
            end
        end
        for (int d = 0; d < DRAIN; d++) begin
            tick();
            chk16($sformatf("%s/drain_nop%0d", name, d), i_datain, 16'h0000);
            chk1($sformatf("%s/drain_busy%0d", name, d), busy, 1'b1);
            chk1($sformatf("%s/drain_done%0d", name, d), done, 1'b0);
            chk1($sformatf("%s/drain_start%0d", name, d), cpu_start, 1'b0);
        end
        tick();
        chk1({name, "/done"}, done, 1'b1);
        chk1({name, "/done_busy"}, busy, 1'b0);
        chk16({name, "/done_nop"}, i_datain, 16'h0000);
        $display("[TB] run %s: %0d words then %0d drain cycles", name, n, DRAIN);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        load_en   = 1'b0;
        load_sel  = 1'b0;
        load_addr = 8'h00;
        load_data = 16'h0000;
        run       = 1'b0;
        d_addr    = 8'h00;
        d_dataout = 16'h0000;
        d_we      = 1'b0;

        // Reset state
        #1;
        chk1("rst/busy", busy, 1'b0);
        chk1("rst/done", done, 1'b0);
        chk1("rst/cpu_start", cpu_start, 1'b0);
        chk16("rst/i_datain", i_datain, 16'h0000);
        chk16("rst/d_datain", d_datain, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset released");

        // Basic run: XOR r1,r2 / NOP / NOP / HALT
        load(1'b0, 8'd0, 16'h4140);
        load(1'b0, 8'd1, 16'h0000);
        load(1'b0, 8'd2, 16'h0000);
        load(1'b0, 8'd3, 16'h0800);
        exp_w[0] = 16'h4140; exp_w[1] = 16'h0000; exp_w[2] = 16'h0000; exp_w[3] = 16'h0800;
        run_prog("basic", 4, 1'b0, 1'b0);

        // No HALT: four plain words, ends on program length
        load(1'b0, 8'd3, 16'h1234);
        exp_w[3] = 16'h1234;
        run_prog("nohalt", 4, 1'b0, 1'b0);

        // run and load during RUN are ignored (a load at addr 7 would grow prog_len)
        run_prog("ignored", 4, 1'b1, 1'b0);

        // HALT in the middle of a longer program stops the stream early
        load(1'b0, 8'd1, 16'h0800);
        load(1'b0, 8'd4, 16'h5555);
        exp_w[1] = 16'h0800;
        run_prog("halt_mid", 2, 1'b0, 1'b0);

        // run together with load in DONE: load dropped, prog[1] still HALT
        run_prog("run_and_load", 2, 1'b0, 1'b1);
        run_prog("rerun", 2, 1'b0, 1'b0);

        // Data RAM: preload 0x10 via load port, then CPU store with read-before-write
        load(1'b1, 8'h10, 16'h1111);
        d_addr = 8'h10;
        tick();
        chk16("ram/preload", d_datain, 16'h1111);
        d_we      = 1'b1;
        d_dataout = 16'hA55A;
        tick();
        d_we = 1'b0;
        chk16("ram/rbw_old", d_datain, 16'h1111);
        tick();
        chk16("ram/new", d_datain, 16'hA55A);
        $display("[TB] ram write 10 <= A55A checked");

        // CPU store and load-port write to the same address: CPU wins
        d_we      = 1'b1;
        d_addr    = 8'h20;
        d_dataout = 16'hBEEF;
        load(1'b1, 8'h20, 16'h1234);
        d_we = 1'b0;
        tick();
        chk16("ram/collide", d_datain, 16'hBEEF);
        $display("[TB] ram collision at 20 checked");

        // Reset mid-run: asynchronous return to IDLE
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        chk1("midrst/busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("midrst/busy", busy, 1'b0);
        chk16("midrst/i_datain", i_datain, 16'h0000);
        chk1("midrst/cpu_start", cpu_start, 1'b0);
        chk1("midrst/done", done, 1'b0);
        reset = 1'b0;
        $display("[TB] reset asserted mid-run");
        tick();

        // prog_len is now 0: START then straight into DRAIN
        run_prog("empty", 0, 1'b0, 1'b0);

        // RAM contents survive reset
        d_addr = 8'h10;
        tick();
        chk16("ram/retained", d_datain, 16'hA55A);
        $display("[TB] ram retained after reset checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_stim_mem.md
# cpu_stim_mem

Memory-side responder for the 16-bit `CPU` core; this is the other end of its `i_datain` / `d_*` interface.
- Holds a small program buffer and streams one instruction word per cycle onto `i_datain` after a run request, with a one-cycle `cpu_start` pulse.
- Serves a 256-word data RAM on the CPU's `d_addr` / `d_dataout` / `d_we` / `d_datain` port.
- Replaces hand-timed stimulus in CPU benches, and later serves as the on-chip memory wrapper.

## Interface
- `PROG_DEPTH`, 16: program buffer words; power of two, at most 256.
- `DRAIN_CYCLES`, 3: NOP words issued after the last program word or after HALT.
- `clock  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state.
- `load_en  in  1`: write one word into the program buffer or the data RAM.
- `load_sel  in  1`: 0 selects the program buffer, 1 selects the data RAM.
- `load_addr  in  8`: load address; for the program buffer only the low log2(`PROG_DEPTH`) bits are used.
- `load_data  in  16`: load word.
- `run  in  1`: start-of-program request; one-cycle pulse.
- `cpu_start  out  1`: start pulse to the CPU.
- `i_datain  out  16`: instruction word to the CPU.
- `d_addr  in  8`: CPU data address.
- `d_dataout  in  16`: CPU store data.
- `d_we  in  1`: CPU store enable.
- `d_datain  out  16`: load data to the CPU.
- `busy  out  1`: high in START, RUN and DRAIN.
- `done  out  1`: high in DONE.

## Operation
- States: IDLE, START, RUN, DRAIN, DONE.
- Reset values:
  - state = IDLE
  - `i_datain` = {NOP, 11'b0}
  - `d_datain` = 0
  - `cpu_start` = 0, `busy` = 0, `done` = 0
  - `prog_len` = 0, `ptr` = 0, drain counter = 0
  - RAM contents are not reset.
- Loading:
  - Accepted only in IDLE or DONE; ignored while `busy`.
  - A program write also sets `prog_len` = max(`prog_len`, addr+1).
- IDLE or DONE, `run`=1:
  - Go to START, `ptr` = 0.
  - `run` wins over a simultaneous `load_en`; the load is dropped.
- START, one cycle:
  - `cpu_start` = 1, `i_datain` = NOP.
  - Next state is RUN; if `prog_len` = 0, go straight to DRAIN.
- RUN:
  - `i_datain` = prog[`ptr`], then `ptr`++.
  - Leave for DRAIN after issuing a word whose bits [15:11] = HALT, or after issuing word `prog_len`-1.
  - `ptr` never wraps.
- DRAIN:
  - `i_datain` = NOP for exactly `DRAIN_CYCLES` cycles, then DONE.
- DONE:
  - `i_datain` = NOP, `done` = 1.
  - Stays in DONE until `run` or reset.
- `run` while `busy` is ignored.
- Data RAM runs in every state, independent of the FSM:
  - `d_we`=1: dmem[`d_addr`] <= `d_dataout` at the clock edge.
  - Every cycle, `d_datain` <= dmem[`d_addr`] (registered read).
  - Read-before-write: a read of the address being written returns the old word; the new word is visible one cycle later.
- Load-port RAM writes in IDLE/DONE coincide with CPU writes only if the CPU is active. If both target the same address in one cycle, the CPU write wins.
- Reset mid-run: return to IDLE immediately, asynchronously; the program buffer and `prog_len` are cleared, and RAM contents are undefined-but-retained.

## Timing
- `run` sampled at edge k:
  - `cpu_start` high in cycle k+1 only.
  - prog[0] on `i_datain` in cycle k+2.
  - prog[n] in cycle k+2+n.
- HALT issued in cycle h: NOPs in cycles h+1 .. h+`DRAIN_CYCLES`; `done` rises in cycle h+`DRAIN_CYCLES`+1.
- Data read latency is 1 cycle: `d_addr` valid in cycle c gives `d_datain` valid in cycle c+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`:
  - 5-bit opcode constants: NOP = 5'b00000, HALT = 5'b00001, and the ALU opcodes including XOR. The CPU uses the same package.
  - State enum for this block.
- One natural sub-module: `dmem_sp256x16`, a synchronous single-write, registered-read RAM. It is reused by the future memory wrapper.
- The program buffer is an inline register array.

## Test plan
- Basic run: load prog = {XOR r1,r2 = 16'hxxxx with op=XOR, NOP, NOP, HALT}, then pulse `run` at edge k.
  - `cpu_start` = 1 at k+1 only.
  - XOR word at k+2, HALT at k+5.
  - NOPs at k+6..k+8; `done` = 1 at k+9.
- No HALT: load 4 words with no HALT, `DRAIN_CYCLES`=3; after word 3, exactly 3 NOPs, then `done`.
- Data RAM:
  - CPU writes `d_addr`=8'h10, `d_dataout`=16'hA55A with `d_we`=1 in cycle c.
  - Same-cycle read returns the old value.
  - A read at c+1 gives `d_datain` = 16'hA55A at c+2.
- Ignored requests: `run` and `load_en` pulsed during RUN are ignored; the sequence and `prog_len` are unchanged.
- Reset mid-run: assert `reset` in RUN.
  - Same cycle: `busy`=0, `i_datain`=16'h0000, `cpu_start`=0.
  - A subsequent `run` with `prog_len`=0 goes START → DRAIN → DONE in 1+3 cycles.
- Simultaneous run and load: `run` and `load_en` together in DONE → START is entered and the load is dropped; prog is unchanged on readback via a rerun.
